// File: rtl/line_win_pkg.sv
// Shared types, default geometry and ring-address helper for the 3x3 line-window sequencer.
package line_win_pkg;

    // Frame-position states: idle, first row, second row, fully primed rows.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME0 = 2'd1,
        PRIME1 = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DEF_LINE_W  = 640;
    localparam int DEF_FRAME_H = 480;
    localparam int DEF_ADR_W   = 10;
    localparam int DEF_CNT_W   = 13;

    // (a + k) mod line_w for a < line_w and k < line_w; a compare-and-subtract
    // keeps it a short adder rather than a divider.
    function automatic int wrap_inc(input int a, input int k, input int line_w);
        int s;
        s = a + k;
        return (s >= line_w) ? (s - line_w) : s;
    endfunction

endpackage

// File: rtl/ring_adr_gen.sv
// Ring address generator: write address at the current column, read and
// prefetch addresses one and two columns ahead, wrapping at LINE_W.
module ring_adr_gen
    import line_win_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADR_W  = DEF_ADR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic [CNT_W-1:0] col,
    output logic [ADR_W-1:0] wr_adr,
    output logic [ADR_W-1:0] rd_adr,
    output logic [ADR_W-1:0] rd_adr2
);

    // Purely combinational address derivation from the column.
    always_comb begin
        wr_adr  = col[ADR_W-1:0];
        rd_adr  = ADR_W'(wrap_inc(int'(col), 1, LINE_W));
        rd_adr2 = ADR_W'(wrap_inc(int'(col), 2, LINE_W));
    end

endmodule

// File: rtl/line_window_ctrl.sv
// Frame-aware sequencer for the 3x3 window datapath: tracks column/row of the
// pixel stream and produces registered row-RAM enables, ring addresses, the
// shift enable and window/frame status.
module line_window_ctrl
    import line_win_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int ADR_W   = DEF_ADR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic [1:0]       row_wr_en,
    output logic [ADR_W-1:0] wr_adr,
    output logic [ADR_W-1:0] rd_adr,
    output logic [ADR_W-1:0] rd_adr2,
    output logic             shift_en,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt,
    output logic             win_valid,
    output logic             frame_done,
    output logic             err_line_len,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(FRAME_H - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t           state;
    state_t           state_next;
    state_t           eff_state;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] row_next;
    logic [CNT_W-1:0] eff_col;
    logic [CNT_W-1:0] eff_row;
    logic             err_next;
    logic             accept;
    logic             at_last_col;
    logic             line_end;
    logic             frame_end;
    logic [ADR_W-1:0] wr_adr_d;
    logic [ADR_W-1:0] rd_adr_d;
    logic [ADR_W-1:0] rd_adr2_d;

    ring_adr_gen #(
        .LINE_W (LINE_W),
        .ADR_W  (ADR_W),
        .CNT_W  (CNT_W)
    ) u_adr (
        .col     (eff_col),
        .wr_adr  (wr_adr_d),
        .rd_adr  (rd_adr_d),
        .rd_adr2 (rd_adr2_d)
    );

    // Next-state and counter logic; in_sof overrides the current position.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        state_next  = state;
        col_next    = col;
        row_next    = row;
        err_next    = err_line_len;
        frame_end   = 1'b0;
        accept      = in_valid && (in_sof || (state != IDLE));
        eff_state   = in_sof ? PRIME0 : state;
        eff_col     = in_sof ? '0 : col;
        eff_row     = in_sof ? '0 : row;
        at_last_col = (eff_col == LAST_COL);
        line_end    = in_eol || at_last_col;

        if (accept) begin
            if (line_end) begin
                // A line ends on in_eol or on column overflow; either way the
                // row advances and the priming state follows the row.
                col_next = '0;
                row_next = eff_row + ONE;
                if (in_eol != at_last_col) begin
                    err_next = 1'b1;
                end
                case (eff_state)
                    PRIME0:  state_next = PRIME1;
                    PRIME1:  state_next = RUN;
                    RUN: begin
                        if (eff_row == LAST_ROW) begin
                            state_next = IDLE;
                            row_next   = '0;
                            frame_end  = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end else begin
                col_next   = eff_col + ONE;
                row_next   = eff_row;
                state_next = eff_state;
            end
        end
    end

    // State, position counters and the sticky line-length error.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            err_line_len <= 1'b0;
        end else begin
            state        <= state_next;
            col          <= col_next;
            row          <= row_next;
            err_line_len <= err_next;
        end
    end

    // Output register: enables pulse for accepted pixels, position/addresses hold on gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_wr_en  <= 2'b00;
            shift_en   <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            wr_adr     <= '0;
            rd_adr     <= '0;
            rd_adr2    <= '0;
        end else begin
            row_wr_en  <= accept ? {(eff_state == PRIME1) || (eff_state == RUN), 1'b1} : 2'b00;
            shift_en   <= accept;
            win_valid  <= accept && (eff_state == RUN) && (eff_col >= TWO);
            frame_done <= frame_end;
            busy       <= (state_next != IDLE);
            if (accept) begin
                col_cnt <= eff_col;
                row_cnt <= eff_row;
                wr_adr  <= wr_adr_d;
                rd_adr  <= rd_adr_d;
                rd_adr2 <= rd_adr2_d;
            end
        end
    end

endmodule
